stage_memory_bus: RTL and testbench
===================================

# stage_memory_bus

Memory-stage bus master sitting directly after `stage_execute` in the pipeline. It uses the ALU result as the effective address and the forwarded rt value as store data, and runs one request/acknowledge transaction per load or store on the external data bus. It generates byte enables and lane-replicated write data, and extracts and sign/zero-extends load data. It also flags misaligned loads, the load-side counterpart of the execute stage's store alignment check. While a transaction is outstanding it stalls the pipeline.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ before forced completion (used only with the timeout feature).
- `clk`  input  1  clock, all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid`  input  1  an instruction occupies the M stage.
- `mem_read`  input  1  instruction is a load.
- `mem_write`  input  1  instruction is a store.
- `mem_type`  input  `MEM_TYPE_LEN`  access size, encoded as `MEM_TYPE_BYTE`/`HALF`/`WORD` from def.v.
- `mem_signed`  input  1  sign-extend load data (lb/lh) when 1, zero-extend when 0.
- `addr`  input  32  effective address (execute-stage ALU result).
- `wdata`  input  32  store data, taken from the low bits.
- `bus_req`  output  1  transaction request, held until acknowledged.
- `bus_we`  output  1  write transaction.
- `bus_addr`  output  32  word address, `{addr[31:2], 2'b00}`.
- `bus_be`  output  4  byte enables.
- `bus_wdata`  output  32  lane-replicated store data.
- `bus_ack`  input  1  responder acknowledge.
- `bus_rdata`  input  32  read word, valid when `bus_ack`=1.
- `stall`  output  1  freeze the F/D/E/M stages.
- `rdata`  output  32  extended load result.
- `load_unaligned`  output  1  misaligned-load exception pulse.
- `bus_error`  output  1  timeout pulse (only with the timeout feature).

## Operation
- An access is `valid && (mem_read || mem_write)`. Both flags high is illegal and is treated as a store.
- Misalignment is half with `addr[0]`=1, or word with `addr[1:0]`≠0. A misaligned access issues no bus transaction and stays in IDLE.
  - Load case: `load_unaligned`=1 combinationally for that cycle.
  - Store case: silently suppressed, because the execute stage has already raised the exception.
  - `stall`=0 in both cases.
- Byte enables:
  - Byte access: `4'b0001 << addr[1:0]`.
  - Half access: `4'b0011 << {addr[1],1'b0}`.
  - Word access: `4'b1111`.
- Write data:
  - Byte access: `{4{wdata[7:0]}}`.
  - Half access: `{2{wdata[15:0]}}`.
  - Word access: `wdata`.
- Load extraction:
  - Byte access selects `bus_rdata[8*addr[1:0] +: 8]`.
  - Half access selects `bus_rdata[16*addr[1] +: 16]`.
  - The selected value is extended per `mem_signed`. Word access passes through unchanged.
- FSM:
  - IDLE: an aligned access latches addr/be/we/wdata/type/signed and moves to REQ.
  - REQ: `bus_req`=1. A sampled `bus_ack`=1 latches the extracted `rdata` and moves to DONE.
  - DONE: one cycle, then back to IDLE. Only an access that is new in the following cycle starts another transaction.
- `stall` = `(IDLE && aligned access) || REQ`. In DONE `stall`=0, so the pipeline advances past the instruction exactly once.
- Bus outputs come only from the latched registers. They are stable for the whole of REQ.
- In IDLE and DONE: `bus_req`=0, `bus_we`=0, `bus_be`=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rdata` all go to 0.
  - `bus_error`=0 and the timeout counter is cleared.
  - Reset during REQ drops `bus_req` without waiting for an acknowledge.
- Latency from an access appearing in cycle 0:
  - Cycle 1 is REQ.
  - If ack arrives in cycle 1, cycle 2 is DONE with `rdata` valid and `stall`=0.
  - Each extra wait cycle adds one cycle.
- `rdata` holds its value after DONE until the next completed load.
- `bus_ack` outside REQ is ignored.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter increments each REQ cycle.
  - When it reaches `TIMEOUT_CYCLES` without an ack, the FSM goes to DONE with `rdata`=0 and `bus_error`=1 for that DONE cycle only.
  - The counter clears on entry to REQ.
- `MEM_BUS_TIMEOUT_EN` undefined:
  - There is no counter and REQ waits indefinitely.
  - `bus_error` is tied to 0 and the parameter is unused.

## Test plan
- lb with `mem_signed`=1, addr=0x1003, ack in the first REQ cycle with `bus_rdata`=0x80FF_FF7F:
  - `bus_addr`=0x1000 and `bus_be`=0b1000.
  - `rdata`=0xFFFF_FF80.
  - `stall` is high for exactly 2 cycles.
- sh, addr=0x2002, wdata=0x1234_ABCD, ack after 3 wait cycles:
  - `bus_be`=0b1100 and `bus_wdata`=0xABCD_ABCD, stable throughout REQ.
  - `stall` is high for 5 cycles.
- lw with addr=0x0006 → `load_unaligned`=1, `bus_req` never rises, `stall`=0.
- lhu with addr=0x0002 and `bus_rdata`=0xBEEF_0000 → `rdata`=0x0000_BEEF.
- Reset asserted mid-REQ → `bus_req` falls before the next edge; after release the state is IDLE and a new access starts a clean transaction.
- With `MEM_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → DONE after 4 REQ cycles with `bus_error`=1 and `rdata`=0.

Source files
------------

// File: rtl/stage_memory_bus.sv
// stage_memory_bus: memory-stage bus master placed after stage_execute.
// Runs one req/ack transaction per aligned load or store and stalls the
// pipeline while it is outstanding. It generates byte enables and lane-replicated
// write data. It extracts and extends load data, and it flags misaligned loads.
// Optional feature: define MEM_BUS_TIMEOUT_EN to bound the REQ state to
// TIMEOUT_CYCLES cycles. A timeout completes the access with rdata=0 and a
// one-cycle bus_error pulse.
module stage_memory_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int MEM_TYPE_LEN = 2,
  parameter logic [MEM_TYPE_LEN-1:0] MEM_TYPE_BYTE = MEM_TYPE_LEN'(0),
  parameter logic [MEM_TYPE_LEN-1:0] MEM_TYPE_HALF = MEM_TYPE_LEN'(1),
  parameter logic [MEM_TYPE_LEN-1:0] MEM_TYPE_WORD = MEM_TYPE_LEN'(2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [MEM_TYPE_LEN-1:0] mem_type,
  input  logic                    mem_signed,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [31:0]             bus_addr,
  output logic [3:0]              bus_be,
  output logic [31:0]             bus_wdata,
  input  logic                    bus_ack,
  input  logic [31:0]             bus_rdata,
  output logic                    stall,
  output logic [31:0]             rdata,
  output logic                    load_unaligned,
  output logic                    bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                  state_q;
  logic                    req_q;
  logic                    we_q;
  logic [3:0]              be_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic [MEM_TYPE_LEN-1:0] type_q;
  logic                    signed_q;

  logic                    is_access;
  logic                    is_store;
  logic                    misaligned;
  logic                    start;
  logic [3:0]              be_d;
  logic [31:0]             wdata_d;
  logic [31:0]             rdata_d;
  logic                    timeout_hit;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             berr_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error   = berr_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // Select the addressed lane of the read word and extend it to 32 bits
  function automatic logic [31:0] extend_load(input logic [31:0]             word,
                                              input logic [MEM_TYPE_LEN-1:0] mtype,
                                              input logic                    sgn,
                                              input logic [1:0]              off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (mtype == MEM_TYPE_BYTE)
      res = {{24{sgn & b[7]}}, b};
    else if (mtype == MEM_TYPE_HALF)
      res = {{16{sgn & h[15]}}, h};
    else
      res = word;
    return res;
  endfunction

  // Decode the access presented in M and its bus lane mapping
  always_comb begin
    is_access  = valid && (mem_read || mem_write);
    is_store   = mem_write;
    misaligned = ((mem_type == MEM_TYPE_HALF) && addr[0]) ||
                 ((mem_type == MEM_TYPE_WORD) && (addr[1:0] != 2'b00));
    start      = (state_q == S_IDLE) && is_access && !misaligned;
    be_d       = 4'b1111;
    wdata_d    = wdata;
    if (mem_type == MEM_TYPE_BYTE) begin
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{wdata[7:0]}};
    end else if (mem_type == MEM_TYPE_HALF) begin
      be_d    = 4'b0011 << {addr[1], 1'b0};
      wdata_d = {2{wdata[15:0]}};
    end
    rdata_d    = extend_load(bus_rdata, type_q, signed_q, addr_q[1:0]);
  end

  assign stall          = start || (state_q == S_REQ);
  assign load_unaligned = (state_q == S_IDLE) && is_access && misaligned && !is_store;
  assign bus_req        = req_q;
  assign bus_we         = we_q;
  assign bus_be         = be_q;
  assign bus_addr       = {addr_q[31:2], 2'b00};
  assign bus_wdata      = wdata_q;
  assign rdata          = rdata_q;

  // Transaction FSM; bus outputs are registered and held for all of REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      type_q   <= '0;
      signed_q <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q    <= '0;
      berr_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_BUS_TIMEOUT_EN
      berr_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_REQ;
            req_q    <= 1'b1;
            we_q     <= is_store;
            be_q     <= be_d;
            addr_q   <= addr;
            wdata_q  <= wdata_d;
            type_q   <= mem_type;
            signed_q <= mem_signed;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            if (!we_q)
              rdata_q <= rdata_d;
          end else if (timeout_hit) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0;
`ifdef MEM_BUS_TIMEOUT_EN
            berr_q  <= 1'b1;
`endif
          end else begin
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          be_q    <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory_bus.sv
// Directed testbench for stage_memory_bus: loads/stores of every size,
// wait states, misalignment, reset during a transaction and the timeout path.
module tb_stage_memory_bus;

  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_type = 2'd0;
  logic        mem_signed = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        load_unaligned;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  // observations captured by run_access
  int          obs_stall;
  int          obs_req;
  logic        obs_stable;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] obs_wdata;
  logic        obs_done_stall;
  logic        obs_done_req;
  logic [31:0] obs_rdata;
  logic        obs_berr;

  stage_memory_bus #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_type(mem_type), .mem_signed(mem_signed),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall), .rdata(rdata),
    .load_unaligned(load_unaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one access, ack it after 'waits' extra REQ cycles, observe through DONE
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] mt,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rword, input int waits);
    @(posedge clk); #1;
    valid = 1'b1; mem_read = rd; mem_write = wr; mem_type = mt;
    mem_signed = sg; addr = a; wdata = wd; bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    obs_stall = 0; obs_req = 0; obs_stable = 1'b1;
    @(negedge clk);
    if (stall) obs_stall++;
    for (int c = 1; c <= waits + 1; c++) begin
      @(posedge clk); #1;
      bus_ack   = (c == waits + 1);
      bus_rdata = (c == waits + 1) ? rword : 32'h5A5A_5A5A;
      @(negedge clk);
      if (stall) obs_stall++;
      if (bus_req) obs_req++;
      if (c == 1) begin
        obs_addr = bus_addr; obs_be = bus_be; obs_we = bus_we; obs_wdata = bus_wdata;
      end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                   bus_we !== obs_we || bus_wdata !== obs_wdata || bus_req !== 1'b1) begin
        obs_stable = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    obs_done_stall = stall; obs_done_req = bus_req;
    obs_rdata = rdata; obs_berr = bus_error;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus_req); end
    checks++; if (bus_be !== 4'b0) begin errors++; $display("FAIL reset_be: got %b expected 0000", bus_be); end
    checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus_addr, bus_wdata); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (stall !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL reset_stall_err: got %b/%b expected 0/0", stall, bus_error); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lb_signed();
    run_access(1'b1, 1'b0, T_BYTE, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0);
    checks++; if (obs_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", obs_addr); end
    checks++; if (obs_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b expected 1000", obs_be); end
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b expected 0", obs_we); end
    checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", obs_rdata); end
    checks++; if (obs_stall != 2) begin errors++; $display("FAIL lb_stall_cycles: got %0d expected 2", obs_stall); end
    checks++; if (obs_done_stall !== 1'b0 || obs_done_req !== 1'b0) begin errors++; $display("FAIL lb_done: got stall=%b req=%b expected 0/0", obs_done_stall, obs_done_req); end
  endtask

  task automatic test_sh_wait();
    run_access(1'b0, 1'b1, T_HALF, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 3);
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
    checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_we_addr: got %b/%h expected 1/00002000", obs_we, obs_addr); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL sh_stable: got %b expected 1", obs_stable); end
    checks++; if (obs_stall != 5 || obs_req != 4) begin errors++; $display("FAIL sh_cycles: got stall=%0d req=%0d expected 5/4", obs_stall, obs_req); end
    checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_rdata_hold: got %h expected ffffff80", obs_rdata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, T_HALF, 1'b0, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 0);
    checks++; if (obs_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata: got %h expected 0000beef", obs_rdata); end
    checks++; if (obs_stall != 2 || obs_be !== 4'b1100) begin errors++; $display("FAIL lhu_stall_be: got %0d/%b expected 2/1100", obs_stall, obs_be); end
    run_access(1'b1, 1'b0, T_HALF, 1'b1, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 0);
    checks++; if (obs_rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata: got %h expected ffffbeef", obs_rdata); end
    run_access(1'b1, 1'b0, T_BYTE, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_A500, 1);
    checks++; if (obs_rdata !== 32'h0000_00A5 || obs_be !== 4'b0010) begin errors++; $display("FAIL lbu_rdata_be: got %h/%b expected 000000a5/0010", obs_rdata, obs_be); end
    run_access(1'b1, 1'b0, T_WORD, 1'b1, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 0);
    checks++; if (obs_rdata !== 32'hCAFE_F00D || obs_be !== 4'b1111) begin errors++; $display("FAIL lw_rdata_be: got %h/%b expected cafef00d/1111", obs_rdata, obs_be); end
    run_access(1'b0, 1'b1, T_BYTE, 1'b0, 32'h0000_0031, 32'hFFFF_FF3C, 32'h0, 0);
    checks++; if (obs_wdata !== 32'h3C3C_3C3C || obs_be !== 4'b0010) begin errors++; $display("FAIL sb_wdata_be: got %h/%b expected 3c3c3c3c/0010", obs_wdata, obs_be); end
    go_idle();
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_type = T_WORD; addr = 32'h0000_0006;
    @(negedge clk);
    checks++; if (load_unaligned !== 1'b1) begin errors++; $display("FAIL lw_unaligned_flag: got %b expected 1", load_unaligned); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_unaligned_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b1; mem_type = T_HALF; addr = 32'h0000_3001; wdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lw_unaligned_req: got %b expected 0", bus_req); end
    checks++; if (load_unaligned !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sh_unaligned: got flag=%b stall=%b expected 0/0", load_unaligned, stall); end
    go_idle();
    checks++; if (bus_req !== 1'b0 || bus_be !== 4'b0) begin errors++; $display("FAIL sh_unaligned_req: got %b/%b expected 0/0000", bus_req, bus_be); end
  endtask

  task automatic test_ack_outside_req();
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL stray_ack: got req=%b stall=%b rdata=%h expected 0/0/cafef00d", bus_req, stall, rdata); end
    go_idle();
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_type = T_WORD; addr = 32'h0000_0010;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", bus_req); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || bus_be !== 4'b0 || bus_addr !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_req: got req=%b be=%b addr=%h rdata=%h expected 0", bus_req, bus_be, bus_addr, rdata); end
    valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_release_idle: got req=%b stall=%b expected 0/0", bus_req, stall); end
    run_access(1'b0, 1'b1, T_WORD, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0);
    checks++; if (obs_addr !== 32'h0000_0020 || obs_be !== 4'b1111 || obs_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_new_sw: got %h/%b/%h expected 00000020/1111/deadbeef", obs_addr, obs_be, obs_wdata); end
    checks++; if (obs_stall != 2 || obs_req != 1) begin errors++; $display("FAIL rst_new_cycles: got stall=%0d req=%0d expected 2/1", obs_stall, obs_req); end
  endtask

  task automatic test_timeout();
    int  reqs;
    logic ended;
    run_access(1'b1, 1'b0, T_BYTE, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_A500, 0);
    checks++; if (obs_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL pre_timeout_rdata: got %h expected 000000a5", obs_rdata); end
`ifdef MEM_BUS_TIMEOUT_EN
    @(posedge clk); #1;
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_type = T_WORD; addr = 32'h0000_0040;
    bus_ack = 1'b0;
    @(negedge clk);
    reqs = 0; ended = 1'b0;
    for (int n = 0; n < 20 && !ended; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_req) reqs++; else ended = 1'b1;
    end
    checks++; if (ended !== 1'b1 || reqs != 4) begin errors++; $display("FAIL timeout_cycles: got ended=%b req=%0d expected 1/4", ended, reqs); end
    checks++; if (bus_error !== 1'b1 || rdata !== 32'h0 || stall !== 1'b0) begin errors++; $display("FAIL timeout_done: got err=%b rdata=%h stall=%b expected 1/0/0", bus_error, rdata, stall); end
    go_idle();
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", bus_error); end
`else
    reqs = 0; ended = 1'b0;
    run_access(1'b1, 1'b0, T_WORD, 1'b0, 32'h0000_0040, 32'h0, 32'h1122_3344, 8);
    reqs = obs_req; ended = obs_stable;
    checks++; if (reqs != 9 || ended !== 1'b1 || obs_stall != 10) begin errors++; $display("FAIL long_wait: got req=%0d stable=%b stall=%0d expected 9/1/10", reqs, ended, obs_stall); end
    checks++; if (obs_rdata !== 32'h1122_3344 || obs_berr !== 1'b0) begin errors++; $display("FAIL long_wait_rdata: got %h err=%b expected 11223344/0", obs_rdata, obs_berr); end
    go_idle();
`endif
  endtask

  initial begin
    test_reset();
    test_lb_signed();
    test_sh_wait();
    test_back_to_back();
    test_misaligned();
    test_ack_outside_req();
    test_reset_mid_req();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
